rv_instr_encoder: RTL
=====================

Name: rv_instr_encoder

Overview:
- Inverse of the team's field parsers: packs RISC-V instruction fields plus a format select into 32-bit RV32I instruction words.
- Buffers the encoded words in a 2-entry output queue and tags each with a sequential byte address.
- Used by the instruction-memory loader and by self-checking benches to generate program images for the pipelined core.

Parameters:
- ADDR_W, 32, width of the generated instruction address.
- BASE_ADDR, 0, byte address tagged on the first word after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle this cycle.
- fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- opcode  input  7  opcode field.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- imm  input  32  immediate value, sign-extended by the producer.
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer takes the word.
- instr  output  32  encoded instruction at the queue head.
- addr  output  ADDR_W  byte address of the head word.
- err  output  1  sticky flag: an illegal fmt was accepted.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values: queue empty, out_valid=0, in_ready=1, instr=0, addr=BASE_ADDR, err=0, address counter=BASE_ADDR.
- Reset asserted mid-operation flushes queued words with no output handshake that cycle.
- Accept: bundle accepted when in_valid && in_ready. Encoding is combinational on the inputs and written into the queue tail at that edge.
- Latency: accept at edge N with an empty queue gives out_valid=1 and the word on instr after edge N. One-cycle latency.
- Pop: occurs when out_valid && out_ready.
- Queue: 2 entries, fill level 0/1/2. in_ready = (level != 2) and is registered-state based.
  - Full with a pop in the same cycle: no push that cycle; in_ready rises the next cycle.
  - Level 1 with a push and a pop in the same cycle: level stays 1 and the head advances to the new word.
  - Full behaves as a 2-deep FIFO; order is preserved.
- Address: each accepted bundle is tagged with the counter value, then the counter += 4. Modulo 2^ADDR_W wrap with no flag. The tag travels with the word.
- Bit packing (i = imm):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: i[11:0], rs1, funct3, rd, opcode.
  - S: i[11:5], rs2, rs1, funct3, i[4:0], opcode.
  - B: i[12], i[10:5], rs2, rs1, funct3, i[4:1], i[11], opcode. i[0] is ignored.
  - U: i[31:12], rd, opcode.
  - J: i[20], i[10:1], i[11], i[19:12], rd, opcode. i[0] is ignored.
  - Fields unused by a format are ignored. Upper imm bits beyond a format's range are ignored; no range check.
- Illegal fmt (6/7): the bundle is still accepted and consumes an address. Word = 32'h00000013 (NOP). err set at the accept edge and held until reset.
- No combinational path from out_ready to in_ready.

Test Plan:
- R add x3,x1,x2 (fmt0, op 0x33, f3 0, f7 0, rd3, rs1 1, rs2 2) after reset, out_ready=1 -> instr=0x002081B3, addr=0x0, out_valid exactly one cycle after accept.
- I addi x5,x0,-1 (op 0x13, imm 0xFFFFFFFF) -> 0xFFF00293. S sw x2,8(x1) (op 0x23, f3 2, imm 8) -> 0x0020A423.
- B beq x1,x2,-4 (op 0x63, imm 0xFFFFFFFC) -> 0xFE208EE3. J jal x1,2048 (op 0x6F, imm 0x800) -> 0x001000EF.
- Backpressure, out_ready=0, three back-to-back bundles -> two accepted, in_ready=0 from the third cycle. Then out_ready=1 drains the words in order with addr 0x0, 0x4; the third is accepted at addr 0x8.
- fmt=7 bundle -> instr=0x00000013, err=1. err stays 1 across later legal words; rst clears err and returns addr to BASE_ADDR.
- rst asserted with 2 words queued -> next cycle out_valid=0 and in_ready=1; the first post-reset word has addr=BASE_ADDR.

Source files
------------

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder
// Packs RISC-V field bundles into 32-bit RV32I instruction words, queues
// them in a 2-entry FIFO and tags each word with a sequential byte address.
// Illegal formats still go through the queue as a NOP and raise a sticky error.

module rv_instr_encoder #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] addr,
    output logic              err
);

    localparam logic [2:0]  FMT_R = 3'd0;
    localparam logic [2:0]  FMT_I = 3'd1;
    localparam logic [2:0]  FMT_S = 3'd2;
    localparam logic [2:0]  FMT_B = 3'd3;
    localparam logic [2:0]  FMT_U = 3'd4;
    localparam logic [2:0]  FMT_J = 3'd5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]       enc_word;
    logic              enc_illegal;

    logic [31:0]       q_instr [2];
    logic [ADDR_W-1:0] q_addr  [2];
    logic              head;
    logic              tail;
    logic [1:0]        level;
    logic [ADDR_W-1:0] addr_cnt;
    logic              err_q;

    logic              push;
    logic              pop;

    // Handshakes are derived from registered fill level only, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (level != 2'd2);
    assign out_valid = (level != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign instr = q_instr[head];
    assign addr  = q_addr[head];
    assign err   = err_q;

    // Bit packing of the field bundle for the selected format.
    always_comb begin
        enc_word    = NOP;
        enc_illegal = 1'b0;
        case (fmt)
            FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], opcode};
            FMT_U: enc_word = {imm[31:12], rd, opcode};
            FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                               rd, opcode};
            default: begin
                enc_word    = NOP;
                enc_illegal = 1'b1;
            end
        endcase
    end

    // Queue storage: the tail slot captures the encoded word and its address tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_instr[0] <= '0;
            q_instr[1] <= '0;
            q_addr[0]  <= BASE_ADDR;
            q_addr[1]  <= BASE_ADDR;
        end else if (push) begin
            q_instr[tail] <= enc_word;
            q_addr[tail]  <= addr_cnt;
        end
    end

    // Queue pointers and fill level; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            level <= 2'd0;
        end else begin
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

    // Address counter advances one word per accepted bundle, wrapping silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= BASE_ADDR;
        end else if (push) begin
            addr_cnt <= addr_cnt + ADDR_W'(4);
        end
    end

    // Sticky error: set when an illegal format is accepted, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (push && enc_illegal) begin
            err_q <= 1'b1;
        end
    end

endmodule
